manchester_decoder_100m: RTL
============================

MANCHESTER_DECODER_100M -- requirements
Module: manchester_decoder_100m

Interface
REQ-001 Parameter HALF_CYC, default 4: clk_sys cycles per Manchester half-bit; SHALL be even and >= 2.
REQ-002 Derived constants SHALL be WIN = 3*HALF_CYC/2 (mid-bit acceptance floor) and TMO = 5*HALF_CYC/2 (lock timeout).
REQ-003 clk_sys  input  1  single system clock (100 MHz), all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_en  input  1  receiver enable; low forces idle.
REQ-006 line_in  input  1  asynchronous Manchester serial line.
REQ-007 bit_out  output  1  decoded bit, valid when bit_valid=1.
REQ-008 bit_valid  output  1  decoded bit available.
REQ-009 bit_ready  input  1  consumer accepts bit_out when high with bit_valid.
REQ-010 locked  output  1  decoder is synchronised to mid-bit transitions.
REQ-011 overflow  output  1  sticky flag: a decoded bit was dropped.
REQ-012 err_cnt  output  16  lock-loss count; present only with MANCH_DEC_ERR_CNT_EN.

Function
REQ-013 line_in SHALL pass through a 2-flop synchroniser plus one history flop; an edge is a difference between the last two stages.
REQ-014 Encoding SHALL be IEEE 802.3: mid-bit rising = 1, mid-bit falling = 0; decoded bit = synchronised line level after the mid-bit edge.
REQ-015 Interval counter cnt, width clog2(TMO+1), SHALL increment each cycle and saturate at TMO.
REQ-016 State HUNT: cnt cleared on every edge; an edge with cnt >= WIN SHALL be taken as mid-bit, emit its bit, clear cnt, go to LOCKED.
REQ-017 State LOCKED: edges with cnt < WIN SHALL be ignored as bit-boundary edges and SHALL NOT clear cnt.
REQ-018 LOCKED: edge with WIN <= cnt <= TMO SHALL emit a bit and clear cnt.
REQ-019 LOCKED: cnt == TMO with no edge that cycle SHALL go to HUNT, clear cnt, drop locked next cycle.
REQ-020 locked SHALL be 1 exactly while state is LOCKED.
REQ-021 Latency: bit_valid SHALL rise 3 clk_sys cycles after the first clock edge sampling the new line_in level at the mid-bit transition.
REQ-022 Output SHALL be a single register: bit_valid and bit_out held stable until bit_valid && bit_ready.
REQ-023 New bit with bit_valid=1, bit_ready=0: new bit dropped, held bit kept, overflow set.
REQ-024 New bit in the same cycle as a completed handshake: new bit loaded, bit_valid stays 1, no overflow.
REQ-025 overflow SHALL remain set until rst or rx_en low.
REQ-026 rx_en low SHALL, next cycle: state HUNT, cnt 0, bit_valid 0, locked 0, overflow 0; synchroniser keeps running; err_cnt retained.
REQ-027 No bit SHALL be emitted while rx_en is low.

Reset
REQ-028 rst high SHALL immediately force bit_out 0, bit_valid 0, locked 0, overflow 0, err_cnt 0, state HUNT, cnt 0, synchroniser flops 0.
REQ-029 rst asserted mid-bit SHALL discard the partial bit; after release the decoder SHALL re-hunt per REQ-016.

Configuration
REQ-030 Macro MANCH_DEC_ERR_CNT_EN defined: err_cnt port and 16-bit counter SHALL exist, +1 per LOCKED->HUNT timeout (REQ-019), saturating at 16'hFFFF, not incremented by rx_en deassertion.
REQ-031 Macro undefined: err_cnt port and counter SHALL be absent; all other behaviour identical.

Verification (HALF_CYC=4, 8 cycles/bit, WIN=6, TMO=10)
REQ-032 rx_en=1, bit_ready=1, send 0,1,0,1 preamble then 1,0,0,1 -> locked=1 at first long interval; bit_out sequence after lock ends 1,0,0,1; no overflow.
REQ-033 Locked, bit_ready=0 over two decoded bits -> first bit held stable, overflow=1 after second; bit_ready=1 -> first bit consumed, overflow stays 1.
REQ-034 Locked, line_in held constant 12 cycles -> locked=0 after cnt reaches 10; err_cnt=1 with macro.
REQ-035 rx_en dropped mid-stream -> next cycle locked=0, bit_valid=0, overflow=0; err_cnt unchanged.
REQ-036 rst pulsed mid-bit -> all outputs 0 without waiting for clk_sys; re-lock on next preamble.
REQ-037 Continuous all-ones stream, no preamble (edges every 4 cycles) -> never locks, bit_valid never asserts.

Source files
------------

// File: rtl/manchester_decoder_100m.sv
// IEEE 802.3 Manchester bit decoder locking onto mid-bit transitions.
// Define MANCH_DEC_ERR_CNT_EN to add the err_cnt lock-loss counter port.
module manchester_decoder_100m #(
    parameter int HALF_CYC = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        rx_en,
    input  logic        line_in,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        locked,
    output logic        overflow
`ifdef MANCH_DEC_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int WIN = 3 * HALF_CYC / 2;
    localparam int TMO = 5 * HALF_CYC / 2;
    localparam int CW  = $clog2(TMO + 1);

    localparam logic [CW-1:0] WIN_C = CW'(WIN);
    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    if (HALF_CYC < 2 || (HALF_CYC % 2) != 0) begin : g_bad_param
        $error("HALF_CYC must be even and >= 2");
    end

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          hist_q,  hist_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          emit_q,  emit_d;
    logic          ebit_q,  ebit_d;
    logic          bout_q,  bout_d;
    logic          bval_q,  bval_d;
    logic          ovf_q,   ovf_d;
    logic          line_edge;
    logic          mid_ok;
`ifdef MANCH_DEC_ERR_CNT_EN
    logic          lock_lost;
    logic [15:0]   err_q,   err_d;
`endif

    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    assign line_edge = sync2_q ^ hist_q;
    assign mid_ok    = cnt_q >= WIN_C;

    // Lock tracking: only edges far enough from the last mid-bit count.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == TMO_C) ? cnt_q : cnt_q + 1'b1;
        emit_d  = 1'b0;
        ebit_d  = ebit_q;
`ifdef MANCH_DEC_ERR_CNT_EN
        lock_lost = 1'b0;
`endif
        if (!rx_en) begin
            state_d = HUNT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (line_edge) begin
                        cnt_d = '0;
                        if (mid_ok) begin
                            emit_d  = 1'b1;
                            ebit_d  = sync2_q;
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (line_edge && mid_ok) begin
                        emit_d = 1'b1;
                        ebit_d = sync2_q;
                        cnt_d  = '0;
                    end else if (!line_edge && cnt_q == TMO_C) begin
                        state_d = HUNT;
                        cnt_d   = '0;
`ifdef MANCH_DEC_ERR_CNT_EN
                        lock_lost = 1'b1;
`endif
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Single-entry output buffer; a bit arriving while full is dropped.
    always_comb begin
        bout_d = bout_q;
        bval_d = bval_q;
        ovf_d  = ovf_q;
        if (!rx_en) begin
            bval_d = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (bval_q && bit_ready) begin
                bval_d = 1'b0;
            end
            if (emit_q) begin
                if (bval_q && !bit_ready) begin
                    ovf_d = 1'b1;
                end else begin
                    bout_d = ebit_q;
                    bval_d = 1'b1;
                end
            end
        end
    end

`ifdef MANCH_DEC_ERR_CNT_EN
    always_comb begin
        err_d = err_q;
        if (lock_lost && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            state_q <= HUNT;
            cnt_q   <= '0;
            emit_q  <= 1'b0;
            ebit_q  <= 1'b0;
            bout_q  <= 1'b0;
            bval_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            emit_q  <= emit_d;
            ebit_q  <= ebit_d;
            bout_q  <= bout_d;
            bval_q  <= bval_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bit_out   = bout_q;
    assign bit_valid = bval_q;
    assign locked    = (state_q == LOCKED);
    assign overflow  = ovf_q;

endmodule
